// File: rtl/unidad_busqueda_pkg.sv
// Shared definitions for the instruction-fetch unit: FSM encoding, widths and
// the default reset PC.
package unidad_busqueda_pkg;

  localparam int XLEN  = 32;
  localparam int JIDX_W = 26;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/unidad_busqueda_siguiente_pc.sv
// Next-PC selection: jr > j > branch > sequential, plus misalignment detect on
// the selected target only.
module siguiente_pc
  import unidad_busqueda_pkg::*;
(
  input  logic [XLEN-1:0]   pc_plus4,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_offset,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              jump_reg,
  input  logic [XLEN-1:0]   reg_target,
  output logic [XLEN-1:0]   next_pc,
  output logic              misaligned
);

  logic signed [XLEN-1:0] base_s;
  logic signed [XLEN-1:0] offset_s;
  logic signed [XLEN-1:0] branch_sum_s;

  // Two's-complement add wraps modulo 2^32, which is the intended behaviour.
  assign base_s       = signed'(pc_plus4);
  assign offset_s     = signed'(branch_offset);
  assign branch_sum_s = base_s + offset_s;

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg)
      next_pc = reg_target;
    else if (jump)
      next_pc = {pc_plus4[31:28], jump_index, 2'b00};
    else if (branch_taken)
      next_pc = unsigned'(branch_sum_s);
  end

  assign misaligned = !is_word_aligned(next_pc);

endmodule

// File: rtl/unidad_busqueda.sv
// Instruction-fetch unit: PC register, req/ack fetch FSM, latched instruction
// and a sticky misalignment trap that parks the unit in HALT.
module unidad_busqueda
  import unidad_busqueda_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          branch_taken,
  input  logic [31:0]   branch_offset,
  input  logic          jump,
  input  logic [25:0]   jump_index,
  input  logic          jump_reg,
  input  logic [31:0]   reg_target,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  output logic [AW-1:0] imem_addr,
  output logic          imem_req,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic          misaligned
);

  fetch_state_t state, state_nxt;
  logic [31:0]  next_pc;
  logic         target_misaligned;
  logic         advance;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc[AW+1:2];

  siguiente_pc u_siguiente_pc (
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .next_pc       (next_pc),
    .misaligned    (target_misaligned)
  );

  assign advance = (state == ST_ISSUE) && enable;

  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        imem_req = 1'b1;
        if (imem_ack)
          state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        instr_valid = 1'b1;
        if (enable)
          state_nxt = target_misaligned ? ST_HALT : ST_WAIT;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A trapping target leaves pc pointing at the offending instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      instr      <= 32'h0;
      misaligned <= 1'b0;
    end else begin
      if (state == ST_WAIT && imem_ack)
        instr <= imem_rdata;
      if (advance && !target_misaligned)
        pc <= next_pc;
      if (advance && target_misaligned)
        misaligned <= 1'b1;
    end
  end

endmodule

// File: tb/tb_unidad_busqueda.sv
// Directed bench for unidad_busqueda: sequential fetch, branches, jumps,
// wait states, stalls, reset mid-fetch and the misalignment trap.
module tb_unidad_busqueda;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] reg_target;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [7:0]  imem_addr;
  logic        imem_req;
  logic [31:0] instr;
  logic        instr_valid;
  logic        misaligned;

  logic        auto_ack;
  logic        man_ack;
  logic [31:0] rdata_xor;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: each word holds 0xC0DE0000 | word index.
  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = {16'hC0DE, 8'h00, imem_addr} ^ rdata_xor;

  unidad_busqueda #(.RESET_PC(32'h0000_0000), .AW(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .reg_target    (reg_target),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .imem_addr     (imem_addr),
    .imem_req      (imem_req),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .misaligned    (misaligned)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_issue();
    int n = 0;
    step();
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
    check("issue_reached", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic issue_ctl(input logic jr, input logic [31:0] rt, input logic j,
                           input logic [25:0] ji, input logic br, input logic [31:0] bo);
    jump_reg = jr; reg_target = rt; jump = j; jump_index = ji;
    branch_taken = br; branch_offset = bo;
    step();
    jump_reg = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    reg_target = 32'h0; jump_index = 26'h0; branch_offset = 32'h0;
  endtask

  task automatic advance_ctl(input logic jr, input logic [31:0] rt, input logic j,
                             input logic [25:0] ji, input logic br, input logic [31:0] bo);
    issue_ctl(jr, rt, j, ji, br, bo);
    run_to_issue();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1;
    branch_taken = 1'b0; branch_offset = 32'h0; jump = 1'b0; jump_index = 26'h0;
    jump_reg = 1'b0; reg_target = 32'h0;
    auto_ack = 1'b1; man_ack = 1'b0; rdata_xor = 32'h0;
    step(); step();

    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_mis", {31'd0, misaligned}, 32'd0);

    // Sequential fetch with zero-wait memory
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("seq_wait_req", {31'd0, imem_req}, 32'd1);
      check("seq_wait_valid", {31'd0, instr_valid}, 32'd0);
      check("seq_pc", pc, 32'(k * 4));
      check("seq_addr", {24'd0, imem_addr}, 32'(k));
      step();
      check("seq_issue_valid", {31'd0, instr_valid}, 32'd1);
      check("seq_issue_req", {31'd0, imem_req}, 32'd0);
      check("seq_instr", instr, 32'hC0DE_0000 | 32'(k));
    end
    check("seq_pc4", pc_plus4, 32'h0000_000C);

    // Branches from pc=0x10
    advance_ctl(1'b1, 32'h10, 1'b0, 26'h0, 1'b0, 32'h0);
    check("jr_0x10", pc, 32'h10);
    advance_ctl(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFF0);
    check("br_back", pc, 32'h04);
    advance_ctl(1'b1, 32'h10, 1'b0, 26'h0, 1'b0, 32'h0);
    advance_ctl(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h20);
    check("br_fwd", pc, 32'h34);

    // Jumps
    advance_ctl(1'b1, 32'h4000_0008, 1'b0, 26'h0, 1'b0, 32'h0);
    check("jr_hi", pc, 32'h4000_0008);
    advance_ctl(1'b0, 32'h0, 1'b1, 26'h000_0040, 1'b0, 32'h0);
    check("j_abs", pc, 32'h4000_0100);
    check("j_addr_alias", {24'd0, imem_addr}, 32'h40);
    advance_ctl(1'b1, 32'h80, 1'b1, 26'h000_0040, 1'b0, 32'h0);
    check("jr_wins", pc, 32'h80);
    advance_ctl(1'b1, 32'h20, 1'b0, 26'h0, 1'b1, 32'h3);
    check("unsel_pc", pc, 32'h20);
    check("unsel_mis", {31'd0, misaligned}, 32'd0);

    // Four wait states, then a 3-cycle stall in ISSUE
    auto_ack = 1'b0;
    issue_ctl(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      check("ws_req", {31'd0, imem_req}, 32'd1);
      check("ws_addr", {24'd0, imem_addr}, 32'h09);
      if (i == 5) man_ack = 1'b1;
      step();
    end
    man_ack = 1'b0;
    check("ws_valid", {31'd0, instr_valid}, 32'd1);
    check("ws_instr", instr, 32'hC0DE_0009);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_pc", pc, 32'h24);
      check("stall_instr", instr, 32'hC0DE_0009);
    end

    // Stray ack in ISSUE must not reload instr
    rdata_xor = 32'hFFFF_FFFF; man_ack = 1'b1;
    step();
    check("stray_instr", instr, 32'hC0DE_0009);
    check("stray_valid", {31'd0, instr_valid}, 32'd1);
    man_ack = 1'b0; rdata_xor = 32'h0; enable = 1'b1; auto_ack = 1'b1;

    // Sequential wrap at the top of the address space
    advance_ctl(1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0, 1'b0, 32'h0);
    check("top_pc", pc, 32'hFFFF_FFFC);
    check("top_addr", {24'd0, imem_addr}, 32'hFF);
    check("top_instr", instr, 32'hC0DE_00FF);
    advance_ctl(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    check("wrap_pc", pc, 32'h0);

    // Reset while waiting for memory
    auto_ack = 1'b0;
    issue_ctl(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    check("midwait_req", {31'd0, imem_req}, 32'd1);
    check("midwait_pc", pc, 32'h4);
    reset = 1'b1;
    step();
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_pc", pc, 32'h0);
    reset = 1'b0; auto_ack = 1'b1;
    run_to_issue();
    check("midrst_instr", instr, 32'hC0DE_0000);

    // Misaligned jr traps into HALT
    issue_ctl(1'b1, 32'h0000_0102, 1'b0, 26'h0, 1'b0, 32'h0);
    auto_ack = 1'b0; man_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("halt_mis", {31'd0, misaligned}, 32'd1);
      check("halt_pc", pc, 32'h0);
      check("halt_req", {31'd0, imem_req}, 32'd0);
      check("halt_valid", {31'd0, instr_valid}, 32'd0);
      check("halt_instr", instr, 32'hC0DE_0000);
      step();
    end
    man_ack = 1'b0; auto_ack = 1'b1;
    reset = 1'b1;
    step();
    check("post_rst_pc", pc, 32'h0);
    check("post_rst_mis", {31'd0, misaligned}, 32'd0);
    check("post_rst_instr", instr, 32'h0);
    reset = 1'b0;
    run_to_issue();
    check("post_rst_fetch", instr, 32'hC0DE_0000);

    // Misaligned branch offset also traps
    issue_ctl(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0006);
    check("br_mis", {31'd0, misaligned}, 32'd1);
    check("br_mis_pc", pc, 32'h0);
    check("br_mis_req", {31'd0, imem_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
